phrase_writer: RTL



---
 rtl/phrase_pkg.sv | 62 ++++++
 rtl/phrase_rom.sv | 32 +++
 rtl/phrase_writer.sv | 130 +++++++++++++
 3 files changed

// File: rtl/phrase_pkg.sv
// Shared definitions for the on-screen phrase writer: game state codes,
// phrase ids, lengths and text, and the writer FSM encoding.
package phrase_pkg;

    // Game FSM state codes as seen on stateGame
    localparam logic [2:0] ST_RESET = 3'b000;
    localparam logic [2:0] ST_START = 3'b001;
    localparam logic [2:0] ST_PAUSE = 3'b010;
    localparam logic [2:0] ST_PLAY  = 3'b011;
    localparam logic [2:0] ST_OVER  = 3'b100;

    // Impossible-looking latch value so the first compare after reset refreshes
    localparam logic [2:0] ST_LATCH_INIT = 3'b111;

    localparam logic [7:0] ASCII_SPACE = 8'h20;

    typedef enum logic [2:0] {
        PH_NONE,
        PH_RESET,
        PH_START,
        PH_PAUSE,
        PH_OVER
    } phrase_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ERASE,
        S_WRITE
    } fsm_e;

    localparam int unsigned LEN_RESET = 10;
    localparam int unsigned LEN_START = 20;
    localparam int unsigned LEN_PAUSE = 11;
    localparam int unsigned LEN_OVER  = 9;

    // Right-aligned packed strings: char i of an L-char phrase is at byte L-1-i
    localparam logic [159:0] STR_RESET = "GAME RESET";
    localparam logic [159:0] STR_START = "PRESS START TO BEGIN";
    localparam logic [159:0] STR_PAUSE = "GAME PAUSED";
    localparam logic [159:0] STR_OVER  = "GAME OVER";

    function automatic phrase_e phrase_of(logic [2:0] st);
        case (st)
            ST_RESET: return PH_RESET;
            ST_START: return PH_START;
            ST_PAUSE: return PH_PAUSE;
            ST_OVER:  return PH_OVER;
            default:  return PH_NONE;
        endcase
    endfunction

    function automatic int unsigned phrase_len(phrase_e p);
        case (p)
            PH_RESET: return LEN_RESET;
            PH_START: return LEN_START;
            PH_PAUSE: return LEN_PAUSE;
            PH_OVER:  return LEN_OVER;
            default:  return 0;
        endcase
    endfunction

endpackage

// File: rtl/phrase_rom.sv
// Combinational phrase text lookup: (phrase id, index) -> ASCII code.
// Ports: id_i phrase id, idx_i character index, char_o ASCII (space if out of range).
module phrase_rom
    import phrase_pkg::*;
#(
    parameter int IDX_W = 5
) (
    input  phrase_e          id_i,
    input  logic [IDX_W-1:0] idx_i,
    output logic [7:0]       char_o
);

    logic [159:0] str;
    int unsigned  len;

    always_comb begin
        str    = '0;
        len    = 0;
        char_o = ASCII_SPACE;
        unique case (id_i)
            PH_RESET: begin str = STR_RESET; len = LEN_RESET; end
            PH_START: begin str = STR_START; len = LEN_START; end
            PH_PAUSE: begin str = STR_PAUSE; len = LEN_PAUSE; end
            PH_OVER:  begin str = STR_OVER;  len = LEN_OVER;  end
            default:  begin str = '0;        len = 0;         end
        endcase
        if (32'(idx_i) < len) begin
            char_o = 8'(str >> (8 * (len - 32'(idx_i) - 1)));
        end
    end

endmodule

// File: rtl/phrase_writer.sv
// Streams the phrase for the current game state into the text renderer,
// blanking the previously shown phrase first. One character per ready/ack.
// Ports: clk, reset (async, active-high), stateGame (game state code),
//   dataReady (renderer ack), ready (request), letters (ASCII),
//   address (character cell), busy (erase or write in progress).
module phrase_writer
    import phrase_pkg::*;
#(
    parameter int BASE_ADDR = 3540,
    parameter int ADDR_W    = 13,
    parameter int MAX_LEN   = 20
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [2:0]        stateGame,
    input  logic              dataReady,
    output logic              ready,
    output logic [7:0]        letters,
    output logic [ADDR_W-1:0] address,
    output logic              busy
);

    localparam int IDX_W = $clog2(MAX_LEN + 1);

    fsm_e              state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [IDX_W-1:0]  shown_q, shown_d;
    logic [2:0]        latched_q, latched_d;
    logic              ready_q, ready_d;
    logic              busy_q, busy_d;
    logic [7:0]        letters_q, letters_d;
    logic [ADDR_W-1:0] address_q, address_d;

    logic              ack;
    logic [IDX_W-1:0]  cur_len;
    logic [IDX_W-1:0]  in_len;
    logic [7:0]        rom_char;

    assign ack     = dataReady & ready_q;
    assign cur_len = IDX_W'(phrase_len(phrase_of(latched_q)));
    assign in_len  = IDX_W'(phrase_len(phrase_of(stateGame)));

    // Outputs are registered from next-state values, so the character for the
    // upcoming index is looked up now and appears together with ready.
    phrase_rom #(.IDX_W(IDX_W)) u_rom (
        .id_i   (phrase_of(latched_d)),
        .idx_i  (idx_d),
        .char_o (rom_char)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            shown_q   <= '0;
            latched_q <= ST_LATCH_INIT;
            ready_q   <= 1'b0;
            busy_q    <= 1'b0;
            letters_q <= ASCII_SPACE;
            address_q <= ADDR_W'(BASE_ADDR);
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            shown_q   <= shown_d;
            latched_q <= latched_d;
            ready_q   <= ready_d;
            busy_q    <= busy_d;
            letters_q <= letters_d;
            address_q <= address_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        shown_d   = shown_q;
        latched_d = latched_q;
        unique case (state_q)
            S_IDLE: begin
                if (stateGame != latched_q) begin
                    latched_d = stateGame;
                    idx_d     = '0;
                    if (shown_q != '0)
                        state_d = S_ERASE;
                    else if (in_len != '0)
                        state_d = S_WRITE;
                end
            end
            S_ERASE: begin
                if (ack) begin
                    if (idx_q == shown_q - IDX_W'(1)) begin
                        shown_d = '0;
                        idx_d   = '0;
                        state_d = (cur_len != '0) ? S_WRITE : S_IDLE;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            S_WRITE: begin
                if (ack) begin
                    if (idx_q == cur_len - IDX_W'(1)) begin
                        shown_d = cur_len;
                        idx_d   = '0;
                        state_d = S_IDLE;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                idx_d   = '0;
            end
        endcase
    end

    always_comb begin
        ready_d   = (state_d != S_IDLE);
        busy_d    = (state_d != S_IDLE);
        letters_d = (state_d == S_WRITE) ? rom_char : ASCII_SPACE;
        address_d = ADDR_W'(BASE_ADDR) + ADDR_W'(idx_d);
    end

    assign ready   = ready_q;
    assign busy    = busy_q;
    assign letters = letters_q;
    assign address = address_q;

endmodule
